// File: rtl/logic_unit_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : logic_unit_pipe
//  Purpose  : Two-stage valid/ready pipelined bitwise logic unit with zero and
//             popcount flags and a saturating completed-transaction counter.
//  Revision : 1.0  initial release
// ============================================================================
module logic_unit_pipe #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           a,
   input  logic [WIDTH-1:0]           b,
   input  logic [2:0]                 op,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           z,
   output logic                       z_zero,
   output logic [$clog2(WIDTH+1)-1:0] z_ones,
   output logic [CNT_W-1:0]           txn_count,
   input  logic                       clr_count
);

   localparam int ONES_W = $clog2(WIDTH+1);

   localparam logic [2:0] OP_ANDN = 3'b000;
   localparam logic [2:0] OP_AND  = 3'b001;
   localparam logic [2:0] OP_OR   = 3'b010;
   localparam logic [2:0] OP_XOR  = 3'b011;
   localparam logic [2:0] OP_NAND = 3'b100;
   localparam logic [2:0] OP_NOR  = 3'b101;
   localparam logic [2:0] OP_XNOR = 3'b110;
   localparam logic [2:0] OP_NOTB = 3'b111;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic              s1_valid_q;
   logic [WIDTH-1:0]  a_q;
   logic [WIDTH-1:0]  b_q;
   logic [2:0]        op_q;

   logic              s2_valid_q;
   logic [WIDTH-1:0]  z_q;
   logic              z_zero_q;
   logic [ONES_W-1:0] z_ones_q;
   logic [CNT_W-1:0]  cnt_q;

   logic [WIDTH-1:0]  z_d;
   logic              z_zero_d;
   logic [ONES_W-1:0] z_ones_d;
   logic [CNT_W-1:0]  cnt_d;

   logic              adv1;
   logic              adv2;

   // A full pipe still accepts when the sink drains stage 2 this cycle.
   assign adv2     = !s2_valid_q || out_ready;
   assign adv1     = !s1_valid_q || adv2;
   assign in_ready = adv1;

   always_comb begin
      z_d = a_q & ~b_q;
      case (op_q)
         OP_ANDN: z_d = a_q & ~b_q;
         OP_AND:  z_d = a_q & b_q;
         OP_OR:   z_d = a_q | b_q;
         OP_XOR:  z_d = a_q ^ b_q;
         OP_NAND: z_d = ~(a_q & b_q);
         OP_NOR:  z_d = ~(a_q | b_q);
         OP_XNOR: z_d = ~(a_q ^ b_q);
         OP_NOTB: z_d = ~b_q;
         default: z_d = a_q & ~b_q;
      endcase
   end

   always_comb begin
      z_ones_d = '0;
      for (int i = 0; i < WIDTH; i++) begin
         z_ones_d = z_ones_d + ONES_W'(z_d[i]);
      end
      z_zero_d = (z_d == '0);
   end

   always_comb begin
      cnt_d = cnt_q;
      if (clr_count) begin
         cnt_d = '0;
      end else if (s2_valid_q && out_ready && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         a_q        <= '0;
         b_q        <= '0;
         op_q       <= '0;
      end else if (adv1) begin
         s1_valid_q <= in_valid;
         if (in_valid) begin
            a_q  <= a;
            b_q  <= b;
            op_q <= op;
         end
      end
   end

   // Result registers only load on a real transaction so an idle pipe keeps z.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid_q <= 1'b0;
         z_q        <= '0;
         z_zero_q   <= 1'b0;
         z_ones_q   <= '0;
      end else if (adv2) begin
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            z_q      <= z_d;
            z_zero_q <= z_zero_d;
            z_ones_q <= z_ones_d;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign out_valid = s2_valid_q;
   assign z         = z_q;
   assign z_zero    = z_zero_q;
   assign z_ones    = z_ones_q;
   assign txn_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_logic_unit_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_logic_unit_pipe
//  Purpose  : Table-driven and directed-sequence bench for logic_unit_pipe.
//  Revision : 1.0  initial release
// ============================================================================
module tb_logic_unit_pipe;

   typedef struct {
      logic [7:0] z;
      logic       zero;
      logic [3:0] ones;
   } res_t;

   typedef struct {
      logic [2:0] op;
      logic [7:0] a;
      logic [7:0] b;
      res_t       r;
   } vec_t;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a;
   logic [7:0] b;
   logic [2:0] op;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] z;
   logic       z_zero;
   logic [3:0] z_ones;
   logic [3:0] txn_count;
   logic       clr_count;

   int   n_chk;
   int   n_fail;
   res_t exp_q[$];
   vec_t tbl[14];
   logic tab_mode;
   res_t tab_exp;
   logic last_acc;
   logic [3:0] cnt_m;

   logic_unit_pipe #(.WIDTH(8), .CNT_W(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .z         (z),
      .z_zero    (z_zero),
      .z_ones    (z_ones),
      .txn_count (txn_count),
      .clr_count (clr_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic res_t model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
      res_t r;
      case (o)
         3'd1:    r.z = x & y;
         3'd2:    r.z = x | y;
         3'd3:    r.z = x ^ y;
         3'd4:    r.z = ~(x & y);
         3'd5:    r.z = ~(x | y);
         3'd6:    r.z = ~(x ^ y);
         3'd7:    r.z = ~y;
         default: r.z = x & ~y;
      endcase
      r.ones = 4'd0;
      for (int i = 0; i < 8; i++) r.ones = r.ones + {3'b000, r.z[i]};
      r.zero = (r.z == 8'h00);
      return r;
   endfunction

   // One clock: sample handshakes before the edge, score, then check after it.
   task automatic cycle();
      logic       acc, hs, stall;
      logic [7:0] zp;
      logic       zzp;
      logic [3:0] zop;
      res_t       e;
      #1;
      acc   = in_valid && in_ready;
      hs    = out_valid && out_ready;
      stall = out_valid && !out_ready;
      zp    = z;
      zzp   = z_zero;
      zop   = z_ones;
      if (hs) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_output", 32'(out_valid), 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("z", 32'(z), 32'(e.z));
            chk("z_zero", 32'(z_zero), 32'(e.zero));
            chk("z_ones", 32'(z_ones), 32'(e.ones));
         end
      end
      if (acc) exp_q.push_back(tab_mode ? tab_exp : model(op, a, b));
      last_acc = acc;
      if (clr_count) cnt_m = 4'd0;
      else if (hs && cnt_m != 4'd15) cnt_m = cnt_m + 4'd1;
      @(posedge clk);
      #1;
      chk("txn_count", 32'(txn_count), 32'(cnt_m));
      if (stall) begin
         chk("stall_valid", 32'(out_valid), 32'd1);
         chk("stall_z", 32'(z), 32'(zp));
         chk("stall_zero", 32'(z_zero), 32'(zzp));
         chk("stall_ones", 32'(z_ones), 32'(zop));
      end
   endtask

   task automatic drain();
      in_valid = 1'b0;
      for (int k = 0; k < 20 && exp_q.size() != 0; k++) cycle();
      chk("drain_empty", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic drive_vec(input int i);
      in_valid = 1'b1;
      a        = tbl[i].a;
      b        = tbl[i].b;
      op       = tbl[i].op;
      tab_exp  = tbl[i].r;
   endtask

   initial begin
      int idx;
      int k;
      int n;
      int pend;

      tbl[0]  = '{3'b000, 8'hF0, 8'h3C, '{8'hC0, 1'b0, 4'd2}};
      tbl[1]  = '{3'b011, 8'hAA, 8'hAA, '{8'h00, 1'b1, 4'd0}};
      tbl[2]  = '{3'b100, 8'hFF, 8'h0F, '{8'hF0, 1'b0, 4'd4}};
      tbl[3]  = '{3'b111, 8'h00, 8'h0F, '{8'hF0, 1'b0, 4'd4}};
      tbl[4]  = '{3'b001, 8'hCC, 8'hAA, '{8'h88, 1'b0, 4'd2}};
      tbl[5]  = '{3'b010, 8'hCC, 8'hAA, '{8'hEE, 1'b0, 4'd6}};
      tbl[6]  = '{3'b011, 8'hCC, 8'hAA, '{8'h66, 1'b0, 4'd4}};
      tbl[7]  = '{3'b101, 8'hCC, 8'hAA, '{8'h11, 1'b0, 4'd2}};
      tbl[8]  = '{3'b110, 8'hCC, 8'hAA, '{8'h99, 1'b0, 4'd4}};
      tbl[9]  = '{3'b000, 8'hCC, 8'hAA, '{8'h44, 1'b0, 4'd2}};
      tbl[10] = '{3'b100, 8'hCC, 8'hAA, '{8'h77, 1'b0, 4'd6}};
      tbl[11] = '{3'b111, 8'hCC, 8'hAA, '{8'h55, 1'b0, 4'd4}};
      tbl[12] = '{3'b010, 8'h00, 8'h00, '{8'h00, 1'b1, 4'd0}};
      tbl[13] = '{3'b101, 8'h00, 8'h00, '{8'hFF, 1'b0, 4'd8}};

      n_chk = 0; n_fail = 0; cnt_m = 4'd0; last_acc = 1'b0;
      tab_mode = 1'b1; tab_exp = '{8'h00, 1'b0, 4'd0};
      rst_n = 1'b0; in_valid = 1'b0; a = 8'h00; b = 8'h00; op = 3'b000;
      out_ready = 1'b1; clr_count = 1'b0;

      // Reset state, before any clock edge
      #3;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_z", 32'(z), 32'd0);
      chk("rst_z_zero", 32'(z_zero), 32'd0);
      chk("rst_z_ones", 32'(z_ones), 32'd0);
      chk("rst_txn_count", 32'(txn_count), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Latency: accepted at edge E0, visible after edge E1
      drive_vec(0);
      cycle();
      in_valid = 1'b0;
      chk("lat_e0_valid", 32'(out_valid), 32'd0);
      cycle();
      chk("lat_e1_valid", 32'(out_valid), 32'd1);
      chk("lat_e1_z", 32'(z), 32'hC0);
      cycle();
      chk("idle_valid", 32'(out_valid), 32'd0);
      chk("idle_z_hold", 32'(z), 32'hC0);
      chk("idle_in_ready", 32'(in_ready), 32'd1);

      // Opcode table, streamed back to back
      for (int i = 0; i < 14; i++) begin
         drive_vec(i);
         cycle();
      end
      drain();

      // Backpressure: only two fit, head result holds, order preserved
      out_ready = 1'b0;
      idx = 0;
      for (int c = 0; c < 4; c++) begin
         drive_vec(4 + idx);
         cycle();
         if (last_acc) idx++;
      end
      chk("bp_accepted", 32'(idx), 32'd2);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_z_head", 32'(z), 32'h88);
      for (int c = 0; c < 2; c++) begin
         a = 8'($urandom); b = 8'($urandom); op = 3'($urandom);
         cycle();
      end
      chk("bp_z_head_junk", 32'(z), 32'h88);
      out_ready = 1'b1;
      drive_vec(4 + idx);
      #1;
      chk("bp_ready_same_cycle", 32'(in_ready), 32'd1);
      k = 0;
      while (idx < 4 && k < 20) begin
         drive_vec(4 + idx);
         cycle();
         if (last_acc) idx++;
         k++;
      end
      chk("bp_all_accepted", 32'(idx), 32'd4);
      drain();

      // Counter saturation and clear-over-increment
      tab_mode = 1'b0;
      clr_count = 1'b1;
      cycle();
      clr_count = 1'b0;
      chk("cnt_cleared", 32'(txn_count), 32'd0);
      n = 0; k = 0;
      in_valid = 1'b1; a = 8'($urandom); b = 8'($urandom); op = 3'($urandom);
      while (n < 17 && k < 60) begin
         cycle();
         if (last_acc) begin
            n++;
            a = 8'($urandom); b = 8'($urandom); op = 3'($urandom);
         end
         k++;
      end
      drain();
      chk("cnt_saturated", 32'(txn_count), 32'd15);
      in_valid = 1'b1; a = 8'h5A; b = 8'h0F; op = 3'b010;
      cycle();
      in_valid = 1'b0;
      cycle();
      chk("clr_hs_valid", 32'(out_valid), 32'd1);
      clr_count = 1'b1;
      cycle();
      clr_count = 1'b0;
      chk("clr_wins", 32'(txn_count), 32'd0);

      // Asynchronous reset with two transactions in flight
      out_ready = 1'b0;
      for (int c = 0; c < 2; c++) begin
         in_valid = 1'b1; a = 8'($urandom); b = 8'($urandom); op = 3'($urandom);
         cycle();
      end
      in_valid = 1'b0;
      chk("pre_rst_valid", 32'(out_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", 32'(out_valid), 32'd0);
      chk("arst_txn_count", 32'(txn_count), 32'd0);
      chk("arst_in_ready", 32'(in_ready), 32'd1);
      chk("arst_z", 32'(z), 32'd0);
      exp_q.delete();
      cnt_m = 4'd0;
      out_ready = 1'b1;
      cycle();
      chk("arst_held_in_ready", 32'(in_ready), 32'd1);
      chk("arst_held_valid", 32'(out_valid), 32'd0);
      rst_n = 1'b1;
      in_valid = 1'b1; a = 8'h3C; b = 8'h0F; op = 3'b011;
      cycle();
      in_valid = 1'b0;
      chk("post_rst_e0_valid", 32'(out_valid), 32'd0);
      cycle();
      chk("post_rst_e1_valid", 32'(out_valid), 32'd1);
      chk("post_rst_z", 32'(z), 32'h33);
      drain();

      // Random valid/ready traffic with a held-until-accepted source
      pend = 0;
      for (int c = 0; c < 400; c++) begin
         if (pend == 0) begin
            if ($urandom_range(0, 3) != 0) begin
               pend = 1;
               in_valid = 1'b1;
               a = 8'($urandom); b = 8'($urandom); op = 3'($urandom);
            end else begin
               in_valid = 1'b0;
            end
         end
         out_ready = ($urandom_range(0, 3) != 0);
         cycle();
         if (last_acc) begin
            pend = 0;
            in_valid = 1'b0;
         end
      end
      out_ready = 1'b1;
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
